cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
Shares one subtract-and-compare datapath between NREQ requesters. The datapath is an ALU doing A - B, followed by a flag-based unsigned comparator.
- Round-robin arbiter picks one pending request, latches its operands and runs the subtraction.
- Returns the ALU flags and the four unsigned relations, tagged with the requester ID, over a valid/ready response channel.
- Sits between client FSMs (sorters, bound checkers) and the shared ALU/comparator resource.

Parameters:
WIDTH, 8, operand width in bits (>=2)
NREQ, 4, number of requesters (>=2)
IDW, $clog2(NREQ), requester ID width (derived, localparam)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot or zero)
req_a  in  NREQ x WIDTH  operand A per requester (unsigned)
req_b  in  NREQ x WIDTH  operand B per requester (unsigned)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  index of requester the response belongs to
rsp_n, rsp_z, rsp_c, rsp_v  out  1 each  ALU flags of A - B
rsp_ge, rsp_le, rsp_gt, rsp_lt  out  1 each  unsigned A>=B, A<=B, A>B, A<B
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE; rr pointer=0.
  - All rsp_* outputs 0; req_ready=0; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching from pointer upward and wrapping at NREQ-1 -> 0.
  - req_ready[grant]=1 combinationally, same cycle. Handshake completes when req_valid[i] & req_ready[i].
  - On handshake: latch a, b and id; next state EXEC.
  - No valid request: stay IDLE, req_ready all 0.
- EXEC (one cycle):
  - diff = {1'b0,A} + {1'b0,~B} + 1, computed in WIDTH+1 bits.
  - C = diff[WIDTH] (1 iff A>=B).
  - Z = (diff[WIDTH-1:0]==0).
  - N = diff[WIDTH-1].
  - V = (A[msb]!=B[msb]) & (N!=A[msb]).
  - Relations: ge=C, lt=~C, gt=C&~Z, le=~C|Z.
  - Flags, relations and id are registered into the rsp_* outputs; next state RESP. req_ready=0.
- RESP:
  - rsp_valid=1. All rsp_* outputs stay stable until rsp_valid & rsp_ready.
  - On response handshake: rsp_valid=0 next cycle; pointer = (id+1) mod NREQ; next state IDLE.
- Latency: request accepted at cycle t -> rsp_valid high at t+2 (rsp_ready held high -> back in IDLE at t+3).
- Maximum throughput: one comparison per 3 cycles.
- Boundary conditions:
  - req_a/req_b changes after acceptance must not affect the result (operands are latched).
  - req_valid dropped while not granted: no effect, no state.
  - All requesters valid continuously: grants rotate 0,1,2,...,NREQ-1,0. No starvation; max wait is NREQ-1 grants.
  - rsp_ready low for many cycles: stay in RESP, no new grant, req_ready all 0.
  - reset asserted mid-operation (EXEC or RESP): immediately IDLE, rsp_valid=0, pending result dropped, pointer=0.
  - A==B: C=1, Z=1 -> ge=1, le=1, gt=0, lt=0.
  - A=0, B=max: C=0, Z=0 -> lt=1, le=1.
  - Pointer wrap: grant NREQ-1 -> pointer 0.

Decomposition:
- Package cmp_pkg:
  - typedef enum state_t {IDLE, EXEC, RESP}.
  - Packed struct flags_t {n,z,c,v}.
  - Packed struct rel_t {ge,le,gt,lt}.
- Sub-module cmp_flags_unit, combinational:
  - Inputs: a, b.
  - Outputs: flags_t and rel_t, using the equations above.
  - Instantiated once and driven from the latched operands.
- Round-robin grant logic stays inline.

Test Plan:
- Reset, then req_valid[0]=1, a=8'd200, b=8'd100, rsp_ready=1 -> rsp_valid at t+2; id=0; c=1, z=0, n=0, v=1; ge=1, gt=1, le=0, lt=0.
- req_valid[2]=1, a=b=8'h3C -> id=2; z=1, c=1; ge=1, le=1, gt=0, lt=0; flags n=0, v=0.
- All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0. Each req_ready pulses exactly one cycle. Responses every 3 cycles.
- Accept a=8'd5, b=8'd9, then hold rsp_ready=0 for 10 cycles -> rsp_* stable. c=0, lt=1, le=1, n=1, diff=8'hFC. req_ready all 0. Then rsp_ready=1 -> IDLE next cycle.
- Assert reset during EXEC -> rsp_valid=0 and busy=0 at once. Next request from requester 3 alone is granted, with id=3.
- Change req_a/req_b the cycle after acceptance (a=0, b=8'hFF accepted) -> response still reports lt=1, c=0, z=0.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types for the compare arbiter
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic ge;
    logic le;
    logic gt;
    logic lt;
  } rel_t;

endpackage

// File: rtl/cmp_flags_unit.sv
// rtl/cmp_flags_unit.sv - A - B subtractor with NZCV flags and unsigned relations
module cmp_flags_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output flags_t           flags_o,
  output rel_t             rel_o
);

  logic [WIDTH:0] diff;

  // Two's-complement subtract; the carry out is the "no borrow" bit.
  assign diff = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  assign flags_o.c = diff[WIDTH];
  assign flags_o.z = (diff[WIDTH-1:0] == '0);
  assign flags_o.n = diff[WIDTH-1];
  assign flags_o.v = (a_i[WIDTH-1] != b_i[WIDTH-1]) & (diff[WIDTH-1] != a_i[WIDTH-1]);

  assign rel_o.ge = flags_o.c;
  assign rel_o.lt = ~flags_o.c;
  assign rel_o.gt = flags_o.c & ~flags_o.z;
  assign rel_o.le = ~flags_o.c | flags_o.z;

endmodule

// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin arbiter sharing one subtract-and-compare datapath
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic                        rsp_n,
  output logic                        rsp_z,
  output logic                        rsp_c,
  output logic                        rsp_v,
  output logic                        rsp_ge,
  output logic                        rsp_le,
  output logic                        rsp_gt,
  output logic                        rsp_lt,
  output logic                        busy
);

  state_t           state_q;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  flags_t           rsp_flags_q;
  rel_t             rsp_rel_q;

  flags_t           flags;
  rel_t             rel;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;

  cmp_flags_unit #(.WIDTH(WIDTH)) u_flags (
    .a_i     (a_q),
    .b_i     (b_q),
    .flags_o (flags),
    .rel_o   (rel)
  );

  // Scan from the pointer upward; the first hit wins, so later slots are skipped.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_valid) req_ready[grant_id] = 1'b1;
  end

  assign ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_flags_q <= '0;
      rsp_rel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            a_q     <= req_a[grant_id];
            b_q     <= req_b[grant_id];
            id_q    <= grant_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_flags_q <= flags;
          rsp_rel_q   <= rel;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_n     = rsp_flags_q.n;
  assign rsp_z     = rsp_flags_q.z;
  assign rsp_c     = rsp_flags_q.c;
  assign rsp_v     = rsp_flags_q.v;
  assign rsp_ge    = rsp_rel_q.ge;
  assign rsp_le    = rsp_rel_q.le;
  assign rsp_gt    = rsp_rel_q.gt;
  assign rsp_lt    = rsp_rel_q.lt;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - self-checking bench for cmp_arbiter against an arithmetic reference model
module tb_cmp_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][W-1:0]   req_a;
  logic [N-1:0][W-1:0]   req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic rsp_n, rsp_z, rsp_c, rsp_v, rsp_ge, rsp_le, rsp_gt, rsp_lt;
  logic                  busy;

  int compared   = 0;
  int mismatched = 0;
  int ptr_m      = 0;

  cmp_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v),
    .rsp_ge(rsp_ge), .rsp_le(rsp_le), .rsp_gt(rsp_gt), .rsp_lt(rsp_lt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected {n,z,c,v,ge,le,gt,lt} from integer arithmetic on the operands.
  function automatic logic [7:0] model(input int a, input int b);
    int d, sa, sb, sd;
    logic [W-1:0] r;
    d  = a - b;
    r  = W'(d);
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sd = sa - sb;
    return {r[W-1], (r == 0), (a >= b),
            (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1))),
            (a >= b), (a <= b), (a > b), (a < b)};
  endfunction

  function automatic logic [7:0] obs_bits();
    return {rsp_n, rsp_z, rsp_c, rsp_v, rsp_ge, rsp_le, rsp_gt, rsp_lt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      req_a[i] = W'($urandom);
      req_b[i] = W'($urandom);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_one(input int id, input int a, input int b, input int hold, input bit chg);
    logic [7:0] e;
    e = model(a, b);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_a[id] = W'(a);
    req_b[id] = W'(b);
    rsp_ready = (hold == 0);
    @(negedge clk);
    check("grant", 32'(req_ready), 32'(1 << id));
    @(posedge clk); #1;
    req_valid = '0;
    if (chg) scramble();
    @(negedge clk);
    check("exec_busy", {busy, rsp_valid, 4'(req_ready)}, {1'b1, 1'b0, 4'b0});
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(id));
    check("rsp_bits", 32'(obs_bits()), 32'(e));
    repeat (hold) begin
      @(posedge clk); #1;
      req_valid = '1;
      scramble();
      @(negedge clk);
      check("hold_stable", {rsp_valid, 2'(rsp_id), obs_bits(), 4'(req_ready)},
            {1'b1, 2'(id), e, 4'b0});
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("pre_hs_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    ptr_m = (id + 1) % N;
    @(negedge clk);
    check("post_hs", {rsp_valid, busy}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    int grants, resps, last_g, cyc;
    int q_id[$];
    logic [7:0] q_e[$];

    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    #12;
    check("reset_outs", {rsp_valid, busy, 4'(req_ready), 2'(rsp_id), obs_bits()}, 16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_one(0, 200, 100, 0, 1'b0);
    run_one(2, 8'h3C, 8'h3C, 0, 1'b0);
    run_one(1, 5, 9, 10, 1'b0);
    run_one(3, 0, 8'hFF, 0, 1'b1);
    repeat (6) run_one(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b1);

    // Reset while in EXEC drops the job and the pointer.
    req_valid = '0;
    req_valid[1] = 1'b1;
    req_a[1] = 8'd7;
    req_b[1] = 8'd3;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    reset = 1'b1;
    #1;
    check("rst_exec", {rsp_valid, busy}, 2'b00);
    #2;
    reset = 1'b0;
    ptr_m = 0;
    @(posedge clk); #1;
    run_one(3, 8'd40, 8'd41, 0, 1'b0);

    // Reset while in RESP, then all requesters valid: rotation restarts at 0.
    req_valid = '0;
    req_valid[2] = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check("resp_before_rst", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_resp", {rsp_valid, busy, obs_bits()}, 10'h0);
    #2;
    reset = 1'b0;
    ptr_m = 0;
    rsp_ready = 1'b1;
    @(negedge clk);

    grants = 0;
    resps  = 0;
    last_g = -1;
    cyc    = 0;
    while (resps < 9 && cyc < 80) begin
      @(posedge clk); #1;
      req_valid = (grants < 9) ? '1 : '0;
      scramble();
      @(negedge clk);
      if (req_ready != 0) begin
        check("rot_grant", 32'(req_ready), 32'(1 << ptr_m));
        if (last_g >= 0) check("rot_spacing", 32'(cyc - last_g), 32'd3);
        last_g = cyc;
        q_id.push_back(ptr_m);
        q_e.push_back(model(int'(req_a[ptr_m]), int'(req_b[ptr_m])));
        grants++;
      end
      if (rsp_valid && rsp_ready) begin
        if (q_id.size() == 0) begin
          check("rot_unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          int id;
          id = q_id.pop_front();
          check("rot_id", 32'(rsp_id), 32'(id));
          check("rot_bits", 32'(obs_bits()), 32'(q_e.pop_front()));
          ptr_m = (id + 1) % N;
        end
        resps++;
      end
      cyc++;
    end
    check("rot_done", 32'(resps), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
